// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
// The divider is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    StateIdle = 3'd0,
    StateMul  = 3'd1,
    StateDiv  = 3'd2,
    StateFix  = 3'd3,
    StateDone = 3'd4
  } muldiv_state_e;

  // True when rs1 is interpreted as a signed value.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One unsigned restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it is non-negative.
module div_restoring_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshakes.
// Define MULDIV_DIV_EN to build the divider; otherwise div ops return illegal.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data,
  output logic            illegal
);

  localparam logic [2:0] StIdle = StateIdle;
  localparam logic [2:0] StMul  = StateMul;
  localparam logic [2:0] StDone = StateDone;

  logic [2:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  // Multiplier: both operands extended to 2*XLEN with op-dependent signedness.
  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    a_sgn   = op_is_signed(op_q);
    b_sgn   = (op_q == OpMulh);
    a_ext   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    b_ext   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_DIV_EN
  localparam logic [2:0] StDiv = StateDiv;
  localparam logic [2:0] StFix = StateFix;
  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, rem_nxt, quo_nxt;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_sgn, rs1_neg, rs2_neg;

  assign in_sgn  = op_is_signed(op);
  assign rs1_neg = in_sgn & rs1_data[XLEN-1];
  assign rs2_neg = in_sgn & rs2_data[XLEN-1];

  div_restoring_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(b_q),
    .rem_out(rem_nxt),
    .quo_out(quo_nxt)
  );
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef MULDIV_DIV_EN
    rem_d     = rem_q;
    quo_d     = quo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d      = op;
          a_d       = rs1_data;
          b_d       = rs2_data;
          illegal_d = 1'b0;
          if (!op[2]) begin
            state_d = StMul;
          end else begin
`ifdef MULDIV_DIV_EN
            // Special cases preload the final values with no sign fix-up.
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            if (rs2_data == '0) begin
              quo_d   = '1;
              rem_d   = rs1_data;
              state_d = StFix;
            end else if (in_sgn && (rs1_data == MinNeg) && (rs2_data == '1)) begin
              quo_d   = MinNeg;
              rem_d   = '0;
              state_d = StFix;
            end else begin
              quo_d     = rs1_neg ? -rs1_data : rs1_data;
              b_d       = rs2_neg ? -rs2_data : rs2_data;
              rem_d     = '0;
              neg_quo_d = rs1_neg ^ rs2_neg;
              neg_rem_d = rs1_neg;
              cnt_d     = CntW'(XLEN);
              state_d   = StDiv;
            end
`else
            illegal_d = 1'b1;
            state_d   = StMul;
`endif
          end
        end
      end
      StMul: begin
        result_d = illegal_q ? '0 : mul_res;
        state_d  = StDone;
      end
`ifdef MULDIV_DIV_EN
      StDiv: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        if (op_q[1]) result_d = neg_rem_q ? -rem_q : rem_q;
        else         result_d = neg_quo_q ? -quo_q : quo_q;
        state_d = StDone;
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign rd_data   = result_q;
  assign illegal   = illegal_q;

endmodule
